// File: rtl/sim_run_ctrl_if.sv
// Bus between a CPU-side test harness (master) and the run controller (slave):
// run control, PC/halt observation, check channels and the latched verdict.
interface sim_run_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 16,
  parameter int NCHK   = 4,
  parameter int DATA_W = 16
);
  logic                     start;
  logic                     abort;
  logic                     halt;
  logic [ADDR_W-1:0]        pc;
  logic [NCHK-1:0]          chk_valid;
  logic [NCHK*DATA_W-1:0]   chk_data;
  logic [NCHK*DATA_W-1:0]   chk_expect;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [2:0]               status;
  logic [CNT_W-1:0]         cycle_count;
  logic [CNT_W-1:0]         err_count;
  logic [NCHK-1:0]          err_mask;

  modport master (
    output start, abort, halt, pc, chk_valid, chk_data, chk_expect,
    input  busy, done, pass, status, cycle_count, err_count, err_mask
  );

  modport slave (
    input  start, abort, halt, pc, chk_valid, chk_data, chk_expect,
    output busy, done, pass, status, cycle_count, err_count, err_mask
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: cycle counting, halt/timeout/stall/abort detection, per-channel
// result compare and one latched verdict held until the next start.

module sim_run_ctrl_lane #(
  parameter int DATA_W = 16
) (
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] exp_d,
  output logic              mis
);
  assign mis = valid && (data != exp_d);
endmodule

module sim_run_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int ADDR_W      = 16,
  parameter int STALL_LIMIT = 1024,
  parameter int DRAIN_CYC   = 8,
  parameter int NCHK        = 4,
  parameter int DATA_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sim_run_ctrl_if.slave bus
);
  localparam int SL_W  = $clog2(STALL_LIMIT);
  localparam int DR_W  = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam int SUM_W = CNT_W + 5;

  localparam logic [CNT_W-1:0] TO_V      = CNT_W'(TIMEOUT);
  localparam logic [SL_W-1:0]  STALL_END = SL_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {
    ST_NONE = 3'd0, ST_PASS = 3'd1, ST_CHECK_FAIL = 3'd2,
    ST_TIMEOUT = 3'd3, ST_STALL = 3'd4, ST_ABORT = 3'd5
  } status_t;

  state_t            state_q, state_n;
  status_t           status_q, status_n;
  logic [CNT_W-1:0]  cyc_q, cyc_n;
  logic [CNT_W-1:0]  err_q, err_n;
  logic [NCHK-1:0]   mask_q, mask_n;
  logic [SL_W-1:0]   stall_q, stall_n;
  logic [ADDR_W-1:0] last_pc_q, last_pc_n;
  logic [DR_W-1:0]   drain_q, drain_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              pass_q, pass_n;

  logic [NCHK-1:0][DATA_W-1:0] dat_v, exp_v;
  logic [NCHK-1:0]             mis;
  logic [4:0]                  mis_cnt;
  logic [SUM_W-1:0]            err_sum;
  logic [CNT_W-1:0]            err_sat;
  logic                        checking;
  logic                        pc_same;

  assign dat_v = bus.chk_data;
  assign exp_v = bus.chk_expect;

  generate
    for (genvar i = 0; i < NCHK; i++) begin : g_lane
      sim_run_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
        .valid (bus.chk_valid[i]),
        .data  (dat_v[i]),
        .exp_d (exp_v[i]),
        .mis   (mis[i])
      );
    end
  endgenerate

  always_comb begin
    mis_cnt = '0;
    for (int i = 0; i < NCHK; i++) mis_cnt = mis_cnt + 5'(mis[i]);
  end

  // Wide sum so several simultaneous mismatches cannot wrap past the saturation point.
  assign err_sum = SUM_W'(err_q) + SUM_W'(mis_cnt);
  assign err_sat = (|err_sum[SUM_W-1:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
  assign pc_same = (bus.pc == last_pc_q);

  function automatic status_t verdict(input logic [CNT_W-1:0] errs);
    return (errs == '0) ? ST_PASS : ST_CHECK_FAIL;
  endfunction

  always_comb begin
    state_n   = state_q;
    status_n  = status_q;
    cyc_n     = cyc_q;
    err_n     = err_q;
    mask_n    = mask_q;
    stall_n   = stall_q;
    last_pc_n = last_pc_q;
    drain_n   = drain_q;
    checking  = (state_q == S_RUN) || (state_q == S_DRAIN);

    if (checking) begin
      err_n  = err_sat;
      mask_n = mask_q | mis;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_n   = S_RUN;
          status_n  = ST_NONE;
          cyc_n     = '0;
          err_n     = '0;
          mask_n    = '0;
          stall_n   = '0;
          last_pc_n = bus.pc;
        end
      end
      S_RUN: begin
        cyc_n     = cyc_q + CNT_W'(1);
        stall_n   = pc_same ? stall_q + SL_W'(1) : '0;
        last_pc_n = bus.pc;
        if (bus.abort) begin
          state_n  = S_DONE;
          status_n = ST_ABORT;
        end else if (bus.halt) begin
          if (DRAIN_CYC == 0) begin
            state_n  = S_DONE;
            status_n = verdict(err_n);
          end else begin
            state_n = S_DRAIN;
            drain_n = DR_W'(DRAIN_CYC);
          end
        end else if (cyc_n == TO_V) begin
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
        end else if (pc_same && stall_n == STALL_END) begin
          state_n  = S_DONE;
          status_n = ST_STALL;
        end
      end
      S_DRAIN: begin
        // Verdict uses err_n so a mismatch on the final drain cycle still counts.
        if (bus.abort) begin
          state_n  = S_DONE;
          status_n = ST_ABORT;
        end else if (drain_q == '0) begin
          state_n  = S_DONE;
          status_n = verdict(err_n);
        end else begin
          drain_n = drain_q - DR_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_RUN) || (state_n == S_DRAIN);
    done_n = (state_n == S_DONE);
    pass_n = done_n && (status_n == ST_PASS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      status_q  <= ST_NONE;
      cyc_q     <= '0;
      err_q     <= '0;
      mask_q    <= '0;
      stall_q   <= '0;
      last_pc_q <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      status_q  <= status_n;
      cyc_q     <= cyc_n;
      err_q     <= err_n;
      mask_q    <= mask_n;
      stall_q   <= stall_n;
      last_pc_q <= last_pc_n;
      drain_q   <= drain_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      pass_q    <= pass_n;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.status      = status_q;
  assign bus.cycle_count = cyc_q;
  assign bus.err_count   = err_q;
  assign bus.err_mask    = mask_q;
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: each run is generated as a per-cycle stimulus
// table, a rule-level model predicts the verdict, and a monitor checks it on done.
module tb_sim_run_ctrl;
  localparam int CNT_W = 8, TIMEOUT = 100, ADDR_W = 16, STALL_LIMIT = 16;
  localparam int DRAIN_CYC = 8, NCHK = 4, DATA_W = 16;
  localparam int MAXC = 140;
  localparam int MAXE = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sim_run_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .NCHK(NCHK), .DATA_W(DATA_W)) bus ();

  sim_run_ctrl #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W), .STALL_LIMIT(STALL_LIMIT),
    .DRAIN_CYC(DRAIN_CYC), .NCHK(NCHK), .DATA_W(DATA_W)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int status;
    int pass;
    int cyc;
    int err;
    int mask;
    int edge_at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;
  logic done_d = 1'b0;

  logic [ADDR_W-1:0]      s_pc    [MAXC];
  logic                   s_halt  [MAXC];
  logic                   s_abort [MAXC];
  logic                   s_start [MAXC];
  logic [NCHK-1:0]        s_vld   [MAXC];
  logic [NCHK*DATA_W-1:0] s_dat   [MAXC];
  logic [NCHK*DATA_W-1:0] s_exp   [MAXC];

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc_no);
    end
  endtask

  // Monitor: every rising done must match the oldest predicted verdict.
  always @(negedge clk) begin
    if (rst_n && bus.done && !done_d) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done with no verdict queued (cycle %0d)", cyc_no);
      end else begin
        mon_e = sbq.pop_front();
        chk("status",      bus.status,      mon_e.status);
        chk("pass",        bus.pass,        mon_e.pass);
        chk("cycle_count", bus.cycle_count, mon_e.cyc);
        chk("err_count",   bus.err_count,   mon_e.err);
        chk("err_mask",    bus.err_mask,    mon_e.mask);
        chk("done_edge",   cyc_no,          mon_e.edge_at);
        chk("busy_at_done", bus.busy,       0);
      end
    end
    done_d <= bus.done;
  end

  task automatic setup(input int base);
    for (int j = 0; j < MAXC; j++) begin
      s_pc[j]    = ADDR_W'(base + j);
      s_halt[j]  = 1'b0;
      s_abort[j] = 1'b0;
      s_start[j] = 1'b0;
      s_vld[j]   = NCHK'($urandom);
      for (int c = 0; c < NCHK; c++) s_exp[j][c*DATA_W +: DATA_W] = DATA_W'($urandom);
      s_dat[j] = s_exp[j];
    end
  endtask

  task automatic mis(input int j, input int c);
    s_vld[j][c] = 1'b1;
    s_dat[j][c*DATA_W +: DATA_W] = s_exp[j][c*DATA_W +: DATA_W] ^ DATA_W'($urandom_range(1, 65535));
  endtask

  // Rule-level prediction: walk the cycles after start, apply exit priorities,
  // count trailing identical pc samples, accumulate saturated mismatch totals.
  task automatic model(output exp_t e, output int last);
    int cyc, err, same, nm, h, st;
    int mask;
    cyc = 0; err = 0; same = 1; h = -1; st = 0; mask = 0; last = -1;
    for (int j = 1; j < MAXC && last < 0; j++) begin
      nm = 0;
      for (int c = 0; c < NCHK; c++)
        if (s_vld[j][c] && s_dat[j][c*DATA_W +: DATA_W] != s_exp[j][c*DATA_W +: DATA_W]) begin
          nm++;
          mask = mask | (1 << c);
        end
      err = (err + nm > MAXE) ? MAXE : err + nm;
      if (h < 0) begin
        cyc  = j;
        same = (s_pc[j] == s_pc[j-1]) ? same + 1 : 1;
        if (s_abort[j]) begin st = 5; last = j; end
        else if (s_halt[j]) h = j;
        else if (cyc == TIMEOUT) begin st = 3; last = j; end
        else if (same >= STALL_LIMIT) begin st = 4; last = j; end
      end else begin
        if (s_abort[j]) begin st = 5; last = j; end
        else if (j == h + DRAIN_CYC + 1) begin st = (err == 0) ? 1 : 2; last = j; end
      end
    end
    e.status = st; e.pass = (st == 1) ? 1 : 0; e.cyc = cyc; e.err = err; e.mask = mask;
    e.edge_at = 0;
  endtask

  task automatic drive(input int j);
    bus.start      = (j == 0) || s_start[j];
    bus.pc         = s_pc[j];
    bus.halt       = s_halt[j];
    bus.abort      = s_abort[j];
    bus.chk_valid  = s_vld[j];
    bus.chk_data   = s_dat[j];
    bus.chk_expect = s_exp[j];
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.halt = 1'b0;
    bus.chk_valid = '0;
  endtask

  task automatic run_scn();
    exp_t e;
    int   last;
    model(e, last);
    if (last > 3 && $urandom_range(0, 1) == 1) s_start[3] = 1'b1;  // ignored while busy
    @(negedge clk);
    e.edge_at = cyc_no + 1 + last;
    sbq.push_back(e);
    for (int j = 0; j <= last + 2 && j < MAXC; j++) begin
      if (j <= last) drive(j);
      else idle_inputs();
      @(negedge clk);
    end
    idle_inputs();
    for (int w = 0; w < 20 && sbq.size() != 0; w++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got no done, required %0d verdict(s) retired", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int k;
    idle_inputs();
    bus.pc = '0; bus.chk_data = '0; bus.chk_expect = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_cycle", bus.cycle_count, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_mask", bus.err_mask, 0);
    rst_n = 1'b1;
    @(negedge clk);

    setup(100); s_halt[50] = 1'b1; run_scn();                              // clean halt
    setup(7);   mis(20, 0); mis(20, 2); s_halt[40] = 1'b1; run_scn();      // ch0+ch2
    setup(3);   run_scn();                                                 // timeout
    setup(3);   s_halt[100] = 1'b1; run_scn();                             // halt beats timeout
    setup(0);   for (int j = 10; j < MAXC; j++) s_pc[j] = 16'h0040; run_scn();  // stall
    setup(0);   for (int j = 10; j < MAXC; j++) s_pc[j] = 16'h0040;
    s_pc[24] = 16'h0041; run_scn();                                        // stall restarts
    setup(9);   s_halt[30] = 1'b1; s_abort[33] = 1'b1; run_scn();          // abort in drain
    setup(9);   s_halt[30] = 1'b1; mis(39, 1); run_scn();                  // last drain cycle
    setup(5);   s_halt[30] = 1'b1; mis(40, 1); run_scn();                  // after done: no effect
    setup(1);   for (int j = 1; j <= 70; j++) for (int c = 0; c < NCHK; c++) mis(j, c);
    s_halt[75] = 1'b1; run_scn();                                          // saturation
    setup(2);   mis(5, 3); s_abort[12] = 1'b1; s_halt[12] = 1'b1; run_scn();  // abort beats halt

    for (int r = 0; r < 30; r++) begin
      setup(int'($urandom_range(0, 65535)));
      for (int j = 1; j < MAXC; j++)
        for (int c = 0; c < NCHK; c++) if ($urandom_range(0, 39) == 0) mis(j, c);
      case ($urandom_range(0, 3))
        0: s_halt[$urandom_range(1, 95)] = 1'b1;
        1: begin
          s_halt[$urandom_range(20, 95)] = 1'b1;
          s_abort[$urandom_range(1, 110)] = 1'b1;
        end
        2: begin
          k = int'($urandom_range(1, 80));
          for (int j = k; j < MAXC; j++) s_pc[j] = s_pc[k];
        end
        default: ;
      endcase
      run_scn();
    end

    // Asynchronous reset in the middle of a run clears everything before the next edge.
    setup(11); mis(4, 1); mis(6, 0);
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin drive(j); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_cycle", bus.cycle_count, 0);
    chk("midrst_err", bus.err_count, 0);
    chk("midrst_mask", bus.err_mask, 0);
    chk("midrst_status", bus.status, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    setup(20); mis(10, 3); s_halt[15] = 1'b1; run_scn();                   // recovery from IDLE

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Synthesisable run controller for processor test benches and FPGA self-test builds. It replaces the free-running "finish after RUNTIME" loop with a parametrised state machine. The block counts cycles, detects processor halt, timeout and PC stall, compares up to NCHK result channels against expected values, and reports one latched verdict. It sits beside the CPU core, observing its PC/halt outputs and selected result buses.

## Interface
- CNT_W, 32, width of cycle and error counters
- TIMEOUT, 1000000, max RUN cycles before timeout verdict (1..2^CNT_W-1)
- ADDR_W, 16, PC width
- STALL_LIMIT, 1024, consecutive RUN cycles with unchanged PC that flag a stall (≥2)
- DRAIN_CYC, 8, cycles after halt during which checks are still accepted (≥0)
- NCHK, 4, number of check channels (1..16)
- DATA_W, 16, width of each check channel

- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run from IDLE or DONE
- abort  in  1  forces termination with ABORT verdict
- halt  in  1  processor halt indication (level)
- pc  in  ADDR_W  current program counter
- chk_valid  in  NCHK  per-channel compare strobe
- chk_data  in  NCHK*DATA_W  observed values, channel i at [i*DATA_W +: DATA_W]
- chk_expect  in  NCHK*DATA_W  expected values, same packing
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  high in DONE when status == PASS
- status  out  3  0 NONE, 1 PASS, 2 CHECK_FAIL, 3 TIMEOUT, 4 STALL, 5 ABORT
- cycle_count  out  CNT_W  RUN cycles elapsed in current/last run
- err_count  out  CNT_W  total mismatches, saturating
- err_mask  out  NCHK  sticky per-channel mismatch flags

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0.
- IDLE/DONE --start--> RUN: cycle_count, err_count, err_mask, stall counter and status cleared; last_pc loaded with pc.
- RUN, per cycle: cycle_count += 1. The stall counter resets when pc != last_pc and increments otherwise; last_pc <= pc.
- RUN exits, priority highest first in the same cycle: abort -> DONE/ABORT; halt -> DRAIN (or DONE if DRAIN_CYC==0); cycle_count reaching TIMEOUT -> DONE/TIMEOUT; stall counter reaching STALL_LIMIT-1 with PC unchanged -> DONE/STALL.
- DRAIN: down-counter from DRAIN_CYC. Checks are still evaluated. abort -> DONE/ABORT. At 0 -> DONE with PASS if err_count==0, else CHECK_FAIL. cycle_count frozen.
- Checks are evaluated in RUN and DRAIN only. Channel i mismatches when chk_valid[i] and data != expect. In a mismatch cycle: err_count += popcount of mismatching channels, saturating at 2^CNT_W-1; err_mask[i] sets and stays set.
- DONE: all outputs hold until start or reset. start in RUN/DRAIN is ignored.
- TIMEOUT/STALL/ABORT verdicts are reported regardless of err_count. err_count/err_mask remain readable.

## Timing
- All state and outputs are registered. Outputs change only on rising clk or on asynchronous reset assertion.
- start sampled at edge N -> busy=1, cycle_count=0 after edge N. First increment is visible after N+1.
- halt sampled at edge H -> busy remains 1, DRAIN entered. done=1 after edge H+DRAIN_CYC+1 (H+1 if DRAIN_CYC==0).
- Timeout: done=1 after the edge on which cycle_count becomes TIMEOUT; cycle_count reads TIMEOUT.
- Stall: done after STALL_LIMIT consecutive sampled cycles with an identical pc.
- Mismatch sampled at edge E -> err_count/err_mask updated after E. A mismatch in the final DRAIN cycle still counts toward the verdict.
- rst_n low mid-run: immediate return to IDLE, all outputs 0. No verdict is retained.

## Test plan
- start, pc increments each cycle, halt at cycle 50, no mismatches, DRAIN_CYC=8 -> done 9 cycles after halt, status=1, pass=1, cycle_count=50.
- Mismatches on channels 0 and 2 in the same cycle, then halt -> err_count=2, err_mask=4'b0101, status=2, pass=0.
- TIMEOUT=100, pc incrementing, no halt -> done with status=3, cycle_count=100. halt and timeout in the same cycle -> DRAIN taken, status=1.
- pc held at 16'h0040 from cycle 10, STALL_LIMIT=16 -> status=4 after 16 identical samples. A single pc change at count 15 resets the counter.
- abort during DRAIN -> status=5 next cycle. Mismatch on the last DRAIN cycle -> status=2. rst_n pulsed low mid-RUN -> busy=0, done=0, counters 0 immediately.
- CNT_W=4, 20 single-channel mismatches -> err_count saturates at 15. Restart from DONE with start -> counters cleared and a new run proceeds.
